// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced MODE/INC buttons step run/set-hours/set-minutes and load next time into digit counters
module time_set_ctrl #(
    parameter int DB_CYCLES = 20000,
    parameter int CNT_W     = 16
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       Btn_Mode,
    input  logic       Btn_Inc,
    input  logic [3:0] Hr_T,
    input  logic [3:0] Hr_U,
    input  logic [3:0] Min_T,
    input  logic [3:0] Min_U,
    output logic [3:0] Load,
    output logic [3:0] Dat_HT,
    output logic [3:0] Dat_HU,
    output logic [3:0] Dat_MT,
    output logic [3:0] Dat_MU,
    output logic       Setting,
    output logic [1:0] Field
);
    localparam logic [1:0] RUN     = 2'b00;
    localparam logic [1:0] SET_HR  = 2'b01;
    localparam logic [1:0] SET_MIN = 2'b10;
    localparam logic [CNT_W-1:0] DB = CNT_W'(DB_CYCLES);

    // bit 1 = mode button, bit 0 = inc button
    logic [1:0] sync1_q, sync2_q, lvl_q, lvl_d, lvl_dly_q, press;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0] state_q, state_d;
    logic [3:0] load_q, load_d, dat_ht_q, dat_ht_d, dat_hu_q, dat_hu_d, dat_mt_q, dat_mt_d, dat_mu_q, dat_mu_d;
    logic       h_ok, m_ok, inc_go;
    logic [4:0] h_sum, h_nxt;
    logic [5:0] m_sum, m_nxt;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            lvl_d[b] = lvl_q[b];
            cnt_d[b] = '0;
            if (sync2_q[b] != lvl_q[b]) begin
                if (cnt_q[b] == DB) lvl_d[b] = ~lvl_q[b];
                else cnt_d[b] = cnt_q[b] + 1'b1;
            end
        end
    end

    assign press = lvl_q & ~lvl_dly_q;

    // out-of-range digits restart the field at 00
    always_comb begin
        h_ok  = Hr_T <= 4'd2 && Hr_U <= 4'd9 && !(Hr_T == 4'd2 && Hr_U > 4'd3);
        m_ok  = Min_T <= 4'd5 && Min_U <= 4'd9;
        h_sum = 5'(Hr_T) * 5'd10 + 5'(Hr_U) + 5'd1;
        m_sum = 6'(Min_T) * 6'd10 + 6'(Min_U) + 6'd1;
        h_nxt = (!h_ok || h_sum == 5'd24) ? 5'd0 : h_sum;
        m_nxt = (!m_ok || m_sum == 6'd60) ? 6'd0 : m_sum;
    end

    always_comb begin
        inc_go   = press[0] & ~press[1];
        state_d  = press[1] ? (state_q == SET_MIN ? RUN : state_q + 2'd1) : state_q;
        load_d   = !inc_go ? 4'b0000 : state_q == SET_HR ? 4'b1100 : state_q == SET_MIN ? 4'b0011 : 4'b0000;
        dat_ht_d = load_d[3] ? 4'(h_nxt / 5'd10) : dat_ht_q;
        dat_hu_d = load_d[2] ? 4'(h_nxt % 5'd10) : dat_hu_q;
        dat_mt_d = load_d[1] ? 4'(m_nxt / 6'd10) : dat_mt_q;
        dat_mu_d = load_d[0] ? 4'(m_nxt % 6'd10) : dat_mu_q;
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_q     <= '0;
            lvl_dly_q <= '0;
            cnt_q     <= '{default: '0};
            state_q   <= RUN;
            load_q    <= '0;
            dat_ht_q  <= '0;
            dat_hu_q  <= '0;
            dat_mt_q  <= '0;
            dat_mu_q  <= '0;
        end else begin
            sync1_q   <= {Btn_Mode, Btn_Inc};
            sync2_q   <= sync1_q;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            load_q    <= load_d;
            dat_ht_q  <= dat_ht_d;
            dat_hu_q  <= dat_hu_d;
            dat_mt_q  <= dat_mt_d;
            dat_mu_q  <= dat_mu_d;
        end
    end

    assign Load    = load_q;
    assign Dat_HT  = dat_ht_q;
    assign Dat_HU  = dat_hu_q;
    assign Dat_MT  = dat_mt_q;
    assign Dat_MU  = dat_mu_q;
    assign Field   = state_q;
    assign Setting = state_q != RUN;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: randomized button presses scored against a queue of expected load strobes
module tb_time_set_ctrl;
    logic       Clk = 0, Clr = 0, Btn_Mode = 0, Btn_Inc = 0;
    logic [3:0] Hr_T = 0, Hr_U = 0, Min_T = 0, Min_U = 0;
    logic [3:0] Load, Dat_HT, Dat_HU, Dat_MT, Dat_MU;
    logic       Setting;
    logic [1:0] Field;

    typedef struct {int cyc; logic [3:0] ld; logic [15:0] dat;} exp_t;
    exp_t       q[$];
    int         vec = 0, errs = 0, cyc = 0, mode = 0;
    logic [15:0] exp_dat = 0;

    time_set_ctrl #(.DB_CYCLES(4), .CNT_W(16)) dut (
        .Clk(Clk), .Clr(Clr), .Btn_Mode(Btn_Mode), .Btn_Inc(Btn_Inc),
        .Hr_T(Hr_T), .Hr_U(Hr_U), .Min_T(Min_T), .Min_U(Min_U),
        .Load(Load), .Dat_HT(Dat_HT), .Dat_HU(Dat_HU), .Dat_MT(Dat_MT), .Dat_MU(Dat_MU),
        .Setting(Setting), .Field(Field)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // scoreboard monitor: every strobe must match the oldest expected one, on time
    always @(negedge Clk) begin
        exp_t e;
        if (q.size() > 0 && cyc > q[0].cyc) begin
            check("missing_load", {28'd0, Load}, {28'd0, q[0].ld});
            void'(q.pop_front());
        end
        if (Clr && Load != 0) begin
            if (q.size() == 0) check("unexpected_load", {28'd0, Load}, 32'd0);
            else begin
                e = q.pop_front();
                check("load_cycle", cyc, e.cyc);
                check("load_bits", {28'd0, Load}, {28'd0, e.ld});
                check("load_data", {16'd0, Dat_HT, Dat_HU, Dat_MT, Dat_MU}, {16'd0, e.dat});
            end
        end
    end

    task automatic set_digits(input int ht, input int hu, input int mt, input int mu);
        Hr_T = 4'(ht); Hr_U = 4'(hu); Min_T = 4'(mt); Min_U = 4'(mu);
    endtask

    // reference: next time value from plain clock arithmetic
    task automatic model(input bit m, input bit i, input int k);
        int h, mm, t, u;
        if (m) mode = (mode + 1) % 3;
        else if (i && mode == 1) begin
            t = Hr_T; u = Hr_U;
            h = (t <= 2 && u <= 9 && !(t == 2 && u > 3)) ? (10 * t + u + 1) % 24 : 0;
            exp_dat[15:8] = {4'(h / 10), 4'(h % 10)};
            q.push_back('{k + 8, 4'b1100, exp_dat});
        end else if (i && mode == 2) begin
            t = Min_T; u = Min_U;
            mm = (t <= 5 && u <= 9) ? (10 * t + u + 1) % 60 : 0;
            exp_dat[7:0] = {4'(mm / 10), 4'(mm % 10)};
            q.push_back('{k + 8, 4'b0011, exp_dat});
        end
    endtask

    task automatic press(input bit m, input bit i, input bit bounce);
        @(negedge Clk);
        if (bounce) repeat (5) begin
            Btn_Inc = 1; repeat (2) @(negedge Clk);
            Btn_Inc = 0; repeat (2) @(negedge Clk);
        end
        Btn_Mode = m; Btn_Inc = i;
        model(m, i, cyc);
        repeat (14) @(negedge Clk);
        Btn_Mode = 0; Btn_Inc = 0;
        repeat (14) @(negedge Clk);
        check("field", {30'd0, Field}, 32'(mode));
        check("setting", {31'd0, Setting}, {31'd0, mode != 0});
    endtask

    initial begin
        for (int n = 0; n < 10; n++) begin
            @(negedge Clk);
            Btn_Mode = n[0]; Btn_Inc = ~n[1];
            check("reset_idle", {25'd0, Load, Setting, Field}, 32'd0);
        end
        Btn_Mode = 0; Btn_Inc = 0;
        @(negedge Clk); Clr = 1;
        repeat (20) @(negedge Clk);
        check("post_reset_idle", {25'd0, Load, Setting, Field}, 32'd0);

        press(1, 0, 0);
        set_digits(2, 3, 4, 4); press(0, 1, 0);
        set_digits(0, 9, 4, 4); press(0, 1, 0);
        set_digits(1, 9, 4, 4); press(0, 1, 0);
        press(1, 0, 0);
        set_digits(1, 1, 5, 9); press(0, 1, 1);
        set_digits(1, 1, 7, 2); press(0, 1, 0);
        set_digits(1, 1, 3, 4); press(0, 1, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        press(1, 1, 0);
        press(1, 0, 0);
        press(1, 0, 0);

        // reset pulse in the middle of a strobe loses the increment
        set_digits(0, 5, 0, 0);
        @(negedge Clk); Btn_Inc = 1;
        repeat (8) @(posedge Clk);
        #1 check("strobe_before_clr", {28'd0, Load}, 32'hC);
        Clr = 0;
        #1 check("clr_mid_strobe", {25'd0, Load, Setting, Field}, 32'd0);
        @(negedge Clk); Clr = 1; mode = 0; exp_dat = 0;
        repeat (14) @(negedge Clk);
        Btn_Inc = 0;
        repeat (14) @(negedge Clk);
        check("field_after_clr", {30'd0, Field}, 32'd0);

        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            set_digits($urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 6), $urandom_range(0, 10));
            if ($urandom_range(0, 9) == 0) Hr_U = 4'hF;
            press(r <= 2 || r == 9, r >= 3, 0);
        end
        repeat (10) @(negedge Clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
